hood_mode_ctrl: RTL and testbench
=================================

// Module: hood_mode_ctrl
// PURPOSE
//  Range-hood mode controller; it produces the mode_state code that the fan/timer display block consumes.
//  Turns button levels into edge events and runs a power/menu/fan FSM.
//  Enforces the one-shot hurricane rule, a timed hurricane exit and an exit cool-down.
//  Outputs a remaining-seconds count for the display.
// PARAMETERS
//  HURRICANE_SEC  60  cycles spent in HURRICANE before auto-drop to MODE2
//  EXIT_SEC       60  cycles spent in COOLDOWN after menu is pressed in HURRICANE
//  IDLE_SEC       30  idle STANDBY cycles before auto power-off (HOOD_IDLE_OFF_EN only)
//  CNT_W          8   countdown width; must hold max(HURRICANE_SEC,EXIT_SEC,IDLE_SEC)
// PORTS
//  clk_1hz         in   1      state clock, 1 Hz
//  rst             in   1      reset, asynchronous, active-low
//  power_btn       in   1      power button level (already synchronised)
//  menu_btn        in   1      menu button level
//  mode1_btn       in   1      gear-1 button level
//  mode2_btn       in   1      gear-2 button level
//  mode3_btn       in   1      hurricane button level
//  mode_state      out  3      000 off/standby, 001 gear1, 010 gear2 or cooldown, 011 hurricane
//  powered         out  1      1 in every state except OFF
//  menu_open       out  1      1 while STANDBY is waiting for a gear select
//  hurricane_used  out  1      hurricane already taken this power session
//  cooldown        out  1      1 in COOLDOWN
//  countdown_sec   out  CNT_W  remaining cycles of HURRICANE/COOLDOWN, else 0
// BEHAVIOUR
//  - Reset (async, rst=0): state OFF; all outputs 0; button history regs 0.
//  - Event x = x_btn & ~x_btn_q, sampled on the clk_1hz rising edge. One event per press, no repeat on hold.
//  - Event priority within a cycle: power > menu > mode3 > mode2 > mode1. Only the highest event acts.
//  - Transitions and outputs are registered: 1-cycle latency from the sampling edge to mode_state.
//  - OFF: power -> STANDBY (menu_open=0). Other events ignored.
//  - Power from any non-OFF state -> OFF. Countdown is cleared and hurricane_used is cleared.
//  - STANDBY: menu toggles menu_open.
//    With menu_open=1: mode1 -> MODE1; mode2 -> MODE2; mode3 -> HURRICANE only if !hurricane_used.
//    A mode event with menu_open=0, or a rejected mode3, is ignored.
//    menu_open clears on leaving STANDBY.
//  - MODE1/MODE2: mode1/mode2 switch gear directly.
//    mode3 -> HURRICANE if !hurricane_used, else ignored. menu -> STANDBY.
//  - HURRICANE:
//    Entry: countdown=HURRICANE_SEC, hurricane_used<=1.
//    Decrements by 1 per cycle. The cycle in which countdown==1 moves to MODE2 with countdown 0.
//    The state therefore lasts exactly HURRICANE_SEC cycles.
//    menu -> COOLDOWN with countdown=EXIT_SEC. mode1/2/3 ignored.
//  - COOLDOWN: mode_state=010, cooldown=1, countdown decrements.
//    countdown==1 -> STANDBY. Only power is honoured.
//  - countdown_sec never wraps below 0. It is forced to 0 in OFF/STANDBY/MODE1/MODE2.
//  - Illegal state encoding -> OFF on the next cycle.
// CONFIGURATION
//  HOOD_IDLE_OFF_EN defined:
//    In STANDBY, an idle counter counts cycles with no event. Any event reloads it.
//    IDLE_SEC idle cycles -> OFF, with the same side effects as power-off.
//    countdown_sec shows the idle remaining value while in STANDBY.
//  HOOD_IDLE_OFF_EN undefined: no idle counter; STANDBY holds indefinitely and countdown_sec=0 there.
// STRUCTURE
//  - hood_pkg: state localparams (S_OFF, S_STANDBY, S_MODE1, S_MODE2, S_HURRICANE, S_COOLDOWN, 3-bit).
//  - hood_pkg: mode codes MODE_IDLE=3'b000, MODE_G1=3'b001, MODE_G2=3'b010, MODE_HUR=3'b011.
//    These are shared with the fan/timer display block.
//  - Sub-module hood_btn_edge: N-bit registered rising-edge detector, instanced once with N=5.
//  - FSM plus a single shared countdown register in this module.
// TESTING
//  - Reset then power press: mode_state 000, powered=1 after 1 cycle; menu, mode2 -> mode_state=010.
//  - From MODE1, mode3: mode_state=011, countdown 60..1 over 60 cycles.
//    Cycle 61: mode_state=010, countdown 0, hurricane_used=1.
//  - Second mode3 from MODE2 after hurricane_used=1 -> stays 010.
//    Power off/on, then menu+mode3 -> 011 accepted.
//  - In HURRICANE at countdown 40, menu -> cooldown=1, mode_state=010, countdown 60..1, then 000.
//    mode1 presses during cooldown are ignored.
//  - Same-cycle menu+mode3 in MODE1 -> STANDBY (priority).
//    Held mode2 for 5 cycles yields one event. rst low mid-HURRICANE -> OFF, all outputs 0.
//  - HOOD_IDLE_OFF_EN: 30 idle cycles in STANDBY -> powered=0.
//    A menu press at idle cycle 29 reloads the count and keeps the hood powered.

Source files
------------

// File: rtl/hood_pkg.sv
// Shared state and mode codes for the range-hood controller and the fan/timer display block.
package hood_pkg;

  localparam logic [2:0] S_OFF       = 3'd0;
  localparam logic [2:0] S_STANDBY   = 3'd1;
  localparam logic [2:0] S_MODE1     = 3'd2;
  localparam logic [2:0] S_MODE2     = 3'd3;
  localparam logic [2:0] S_HURRICANE = 3'd4;
  localparam logic [2:0] S_COOLDOWN  = 3'd5;

  localparam logic [2:0] MODE_IDLE = 3'b000;
  localparam logic [2:0] MODE_G1   = 3'b001;
  localparam logic [2:0] MODE_G2   = 3'b010;
  localparam logic [2:0] MODE_HUR  = 3'b011;

  // Field order matches event priority, highest first.
  typedef struct packed {
    logic power;
    logic menu;
    logic mode3;
    logic mode2;
    logic mode1;
  } hood_evt_t;

  function automatic logic [2:0] mode_code(input logic [2:0] state);
    case (state)
      S_MODE1:     mode_code = MODE_G1;
      S_MODE2:     mode_code = MODE_G2;
      S_HURRICANE: mode_code = MODE_HUR;
      S_COOLDOWN:  mode_code = MODE_G2;
      default:     mode_code = MODE_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/hood_btn_edge.sv
// N-bit rising-edge detector: one event per press, nothing while a button is held.
module hood_btn_edge #(
  parameter int unsigned N = 5
) (
  input  logic         clk_1hz,
  input  logic         rst,
  input  logic [N-1:0] btn,
  output logic [N-1:0] evt
);

  logic [N-1:0] btn_q;

  always_ff @(posedge clk_1hz or negedge rst) begin
    if (!rst) begin
      btn_q <= '0;
    end else begin
      btn_q <= btn;
    end
  end

  assign evt = btn & ~btn_q;

endmodule

// File: rtl/hood_mode_ctrl.sv
// Range-hood power/menu/fan FSM with one-shot hurricane, timed exit and cool-down.
// Optional STANDBY idle auto-off is enabled by defining HOOD_IDLE_OFF_EN.
module hood_mode_ctrl
  import hood_pkg::*;
#(
  parameter int unsigned HURRICANE_SEC = 60,
  parameter int unsigned EXIT_SEC      = 60,
  parameter int unsigned IDLE_SEC      = 30,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk_1hz,
  input  logic             rst,
  input  logic             power_btn,
  input  logic             menu_btn,
  input  logic             mode1_btn,
  input  logic             mode2_btn,
  input  logic             mode3_btn,
  output logic [2:0]       mode_state,
  output logic             powered,
  output logic             menu_open,
  output logic             hurricane_used,
  output logic             cooldown,
  output logic [CNT_W-1:0] countdown_sec
);

`ifdef HOOD_IDLE_OFF_EN
  localparam bit IdleOffEn = 1'b1;
`else
  localparam bit IdleOffEn = 1'b0;
`endif

  localparam logic [CNT_W-1:0] HurLoad  = CNT_W'(HURRICANE_SEC);
  localparam logic [CNT_W-1:0] ExitLoad = CNT_W'(EXIT_SEC);
  // The shared countdown doubles as the idle timer in STANDBY when auto-off is built in.
  localparam logic [CNT_W-1:0] IdleLoad = IdleOffEn ? CNT_W'(IDLE_SEC) : '0;
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

  logic [4:0]       evt_vec;
  hood_evt_t        ev;
  logic             any_evt;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             menu_q, menu_d;
  logic             used_q, used_d;
  logic             go_off;

  hood_btn_edge #(
    .N(5)
  ) u_btn_edge (
    .clk_1hz(clk_1hz),
    .rst    (rst),
    .btn    ({power_btn, menu_btn, mode3_btn, mode2_btn, mode1_btn}),
    .evt    (evt_vec)
  );

  assign ev      = evt_vec;
  assign any_evt = |evt_vec;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    menu_d  = menu_q;
    used_d  = used_q;
    go_off  = 1'b0;
    case (state_q)
      S_OFF: begin
        cnt_d  = '0;
        menu_d = 1'b0;
        used_d = 1'b0;
        if (ev.power) begin
          state_d = S_STANDBY;
          cnt_d   = IdleLoad;
        end
      end
      S_STANDBY: begin
        if (ev.power) begin
          go_off = 1'b1;
        end else if (any_evt) begin
          cnt_d = IdleLoad;
          if (ev.menu) begin
            menu_d = ~menu_q;
          end else if (menu_q) begin
            if (ev.mode3) begin
              if (!used_q) begin
                state_d = S_HURRICANE;
                cnt_d   = HurLoad;
                used_d  = 1'b1;
                menu_d  = 1'b0;
              end
            end else if (ev.mode2) begin
              state_d = S_MODE2;
              cnt_d   = '0;
              menu_d  = 1'b0;
            end else begin
              state_d = S_MODE1;
              cnt_d   = '0;
              menu_d  = 1'b0;
            end
          end
        end else if (IdleOffEn) begin
          if (cnt_q <= CntOne) begin
            go_off = 1'b1;
          end else begin
            cnt_d = cnt_q - CntOne;
          end
        end
      end
      S_MODE1, S_MODE2: begin
        cnt_d = '0;
        if (ev.power) begin
          go_off = 1'b1;
        end else if (ev.menu) begin
          state_d = S_STANDBY;
          menu_d  = 1'b0;
          cnt_d   = IdleLoad;
        end else if (ev.mode3) begin
          if (!used_q) begin
            state_d = S_HURRICANE;
            cnt_d   = HurLoad;
            used_d  = 1'b1;
          end
        end else if (ev.mode2) begin
          state_d = S_MODE2;
        end else if (ev.mode1) begin
          state_d = S_MODE1;
        end
      end
      S_HURRICANE: begin
        if (ev.power) begin
          go_off = 1'b1;
        end else if (ev.menu) begin
          state_d = S_COOLDOWN;
          cnt_d   = ExitLoad;
        end else if (cnt_q <= CntOne) begin
          state_d = S_MODE2;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      S_COOLDOWN: begin
        if (ev.power) begin
          go_off = 1'b1;
        end else if (cnt_q <= CntOne) begin
          state_d = S_STANDBY;
          menu_d  = 1'b0;
          cnt_d   = IdleLoad;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      default: go_off = 1'b1;
    endcase
    if (go_off) begin
      state_d = S_OFF;
      cnt_d   = '0;
      menu_d  = 1'b0;
      used_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_1hz or negedge rst) begin
    if (!rst) begin
      state_q <= S_OFF;
      cnt_q   <= '0;
      menu_q  <= 1'b0;
      used_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      menu_q  <= menu_d;
      used_q  <= used_d;
    end
  end

  assign mode_state     = mode_code(state_q);
  assign powered        = state_q inside {S_STANDBY, S_MODE1, S_MODE2, S_HURRICANE, S_COOLDOWN};
  assign menu_open      = menu_q;
  assign hurricane_used = used_q;
  assign cooldown       = (state_q == S_COOLDOWN);
  assign countdown_sec  = cnt_q;

endmodule

// File: tb/tb_hood_mode_ctrl.sv
// Directed scoreboard bench for hood_mode_ctrl; idle auto-off steps follow HOOD_IDLE_OFF_EN.
module tb_hood_mode_ctrl;

  logic       clk_1hz = 1'b0;
  logic       rst = 1'b0;
  logic       power_btn = 1'b0, menu_btn = 1'b0;
  logic       mode1_btn = 1'b0, mode2_btn = 1'b0, mode3_btn = 1'b0;
  logic [2:0] mode_state;
  logic       powered, menu_open, hurricane_used, cooldown;
  logic [7:0] countdown_sec;
  logic [14:0] obs;

  localparam logic [4:0] B_NONE = 5'b00000;
  localparam logic [4:0] B_PWR  = 5'b10000;
  localparam logic [4:0] B_MENU = 5'b01000;
  localparam logic [4:0] B_M3   = 5'b00100;
  localparam logic [4:0] B_M2   = 5'b00010;
  localparam logic [4:0] B_M1   = 5'b00001;

  typedef struct {
    string       tag;
    logic [14:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass = 0;

  hood_mode_ctrl dut (
    .clk_1hz       (clk_1hz),
    .rst           (rst),
    .power_btn     (power_btn),
    .menu_btn      (menu_btn),
    .mode1_btn     (mode1_btn),
    .mode2_btn     (mode2_btn),
    .mode3_btn     (mode3_btn),
    .mode_state    (mode_state),
    .powered       (powered),
    .menu_open     (menu_open),
    .hurricane_used(hurricane_used),
    .cooldown      (cooldown),
    .countdown_sec (countdown_sec)
  );

  always #5 clk_1hz = ~clk_1hz;

  assign obs = {mode_state, powered, menu_open, hurricane_used, cooldown, countdown_sec};

  function automatic logic [14:0] pk(input logic [2:0] m, input logic pw, input logic mo,
                                     input logic used, input logic cool, input int cnt);
    return {m, pw, mo, used, cool, 8'(cnt)};
  endfunction

  // STANDBY countdown shows the idle timer only when auto-off is built in.
  function automatic int sbc(input int v);
`ifdef HOOD_IDLE_OFF_EN
    return v;
`else
    return 0;
`endif
  endfunction

  function automatic logic [14:0] stby(input logic mo, input logic used, input int v);
    return pk(3'b000, 1'b1, mo, used, 1'b0, sbc(v));
  endfunction

  task automatic push(input string tag, input logic [14:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    e = sb_q.pop_front();
    n_checks++;
    assert (obs === e.val) n_pass++;
    else $error("FAIL %s observed mode=%b pw=%b menu=%b used=%b cool=%b cnt=%0d expected mode=%b pw=%b menu=%b used=%b cool=%b cnt=%0d",
                e.tag, obs[14:12], obs[11], obs[10], obs[9], obs[8], obs[7:0],
                e.val[14:12], e.val[11], e.val[10], e.val[9], e.val[8], e.val[7:0]);
  endtask

  task automatic step(input string tag, input logic [4:0] b, input logic [14:0] v);
    @(negedge clk_1hz);
    {power_btn, menu_btn, mode3_btn, mode2_btn, mode1_btn} = b;
    push(tag, v);
    @(posedge clk_1hz);
    #1;
    pop_check();
  endtask

  initial begin
    #12;
    push("reset_state", 15'd0);
    pop_check();
    @(negedge clk_1hz);
    rst = 1'b1;
    step("off_idle", B_NONE, 15'd0);

    // Power on, menu, gear select
    step("power_on", B_PWR, stby(0, 0, 30));
    step("stby_rel", B_NONE, stby(0, 0, 29));
    step("menu_open", B_MENU, stby(1, 0, 30));
    step("menu_rel", B_NONE, stby(1, 0, 29));
    step("sel_mode2", B_M2, pk(3'b010, 1, 0, 0, 0, 0));
    step("mode2_rel", B_NONE, pk(3'b010, 1, 0, 0, 0, 0));
    step("sel_mode1", B_M1, pk(3'b001, 1, 0, 0, 0, 0));
    step("mode1_rel", B_NONE, pk(3'b001, 1, 0, 0, 0, 0));

    // Full hurricane run
    step("hur_enter", B_M3, pk(3'b011, 1, 0, 1, 0, 60));
    for (int k = 1; k <= 59; k++) step("hur_count", B_NONE, pk(3'b011, 1, 0, 1, 0, 60 - k));
    step("hur_expire", B_NONE, pk(3'b010, 1, 0, 1, 0, 0));
    step("hur_reject", B_M3, pk(3'b010, 1, 0, 1, 0, 0));
    step("reject_rel", B_NONE, pk(3'b010, 1, 0, 1, 0, 0));

    // Power cycle clears hurricane_used; same-cycle menu+mode3 priority
    step("power_off", B_PWR, 15'd0);
    step("off_rel", B_NONE, 15'd0);
    step("power_on2", B_PWR, stby(0, 0, 30));
    step("stby_rel2", B_NONE, stby(0, 0, 29));
    step("menu_open2", B_MENU, stby(1, 0, 30));
    step("menu_rel2", B_NONE, stby(1, 0, 29));
    step("sel_mode1b", B_M1, pk(3'b001, 1, 0, 0, 0, 0));
    step("mode1_rel2", B_NONE, pk(3'b001, 1, 0, 0, 0, 0));
    step("prio_menu", B_MENU | B_M3, stby(0, 0, 30));
    step("prio_rel", B_NONE, stby(0, 0, 29));
    step("menu_open3", B_MENU, stby(1, 0, 30));
    step("menu_rel3", B_NONE, stby(1, 0, 29));
    step("hur_again", B_M3, pk(3'b011, 1, 0, 1, 0, 60));

    // Exit at countdown 40 into cool-down, non-power presses ignored
    for (int k = 1; k <= 20; k++) step("hur_count2", B_NONE, pk(3'b011, 1, 0, 1, 0, 60 - k));
    step("cool_enter", B_MENU, pk(3'b010, 1, 0, 1, 1, 60));
    for (int k = 1; k <= 59; k++) begin
      step("cool_count", (k % 2 == 1) ? (B_MENU | B_M3 | B_M2 | B_M1) : B_NONE,
           pk(3'b010, 1, 0, 1, 1, 60 - k));
    end
    step("cool_done", B_NONE, stby(0, 1, 30));

    // Held mode2 yields a single event
    step("menu_open4", B_MENU, stby(1, 1, 30));
    step("menu_rel4", B_NONE, stby(1, 1, 29));
    step("sel_mode1c", B_M1, pk(3'b001, 1, 0, 1, 0, 0));
    step("mode1_rel3", B_NONE, pk(3'b001, 1, 0, 1, 0, 0));
    step("hold_c1", B_M2, pk(3'b010, 1, 0, 1, 0, 0));
    step("hold_c2", B_M2 | B_M1, pk(3'b001, 1, 0, 1, 0, 0));
    for (int k = 3; k <= 5; k++) step("hold_cn", B_M2, pk(3'b001, 1, 0, 1, 0, 0));
    step("hold_rel", B_NONE, pk(3'b001, 1, 0, 1, 0, 0));

    // Asynchronous reset mid-hurricane
    step("power_off2", B_PWR, 15'd0);
    step("off_rel2", B_NONE, 15'd0);
    step("power_on3", B_PWR, stby(0, 0, 30));
    step("stby_rel3", B_NONE, stby(0, 0, 29));
    step("menu_open5", B_MENU, stby(1, 0, 30));
    step("menu_rel5", B_NONE, stby(1, 0, 29));
    step("hur_enter3", B_M3, pk(3'b011, 1, 0, 1, 0, 60));
    step("hur_c59", B_NONE, pk(3'b011, 1, 0, 1, 0, 59));
    step("hur_c58", B_NONE, pk(3'b011, 1, 0, 1, 0, 58));
    #2;
    rst = 1'b0;
    #1;
    push("rst_async", 15'd0);
    pop_check();
    @(negedge clk_1hz);
    rst = 1'b1;
    step("post_rst", B_NONE, 15'd0);

    step("power_on4", B_PWR, stby(0, 0, 30));
`ifdef HOOD_IDLE_OFF_EN
    for (int k = 1; k <= 28; k++) step("idle_count", B_NONE, stby(0, 0, 30 - k));
    step("idle_reload", B_MENU, stby(1, 0, 30));
    for (int k = 1; k <= 29; k++) step("idle_count2", B_NONE, stby(1, 0, 30 - k));
    step("idle_off", B_NONE, 15'd0);
`else
    for (int k = 1; k <= 40; k++) step("stby_hold", B_NONE, stby(0, 0, 0));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
